// File: rtl/reg_rstn_mode_n_en_y_if.sv
// Data and load-enable bundle for the enabled D-type register.
// The master drives the enable and the data. The slave returns the registered value.
interface reg_rstn_mode_n_en_y_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  i_en;
    logic [DATA_WIDTH-1:0] i_data;
    logic [DATA_WIDTH-1:0] o_data;

    modport master (
        output i_en,
        output i_data,
        input  o_data
    );

    modport slave (
        input  i_en,
        input  i_data,
        output o_data
    );
endinterface

// File: rtl/reg_rstn_mode_n_en_y.sv
// D-type register with a synchronous load-enable and an asynchronous active-low reset.
// Reset always forces the fixed value RST_VAL.
module reg_rstn_mode_n_en_y #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]      RST_VAL    = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    reg_rstn_mode_n_en_y_if.slave   bus
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (bus.i_en) begin
            data_d = bus.i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.o_data = data_q;

    // An unknown enable while out of reset would corrupt the held value.
    en_known_a : assert property (@(posedge i_clk) disable iff (!i_rst_n) !$isunknown(bus.i_en))
        else $error("i_en is unknown at a clock edge while out of reset");

endmodule

// File: tb/tb_reg_rstn_mode_n_en_y.sv
// Directed bench for reg_rstn_mode_n_en_y.
// It runs two instances side by side: one with RST_VAL = 0 and one with RST_VAL = 32'hDEADBEEF.
module tb_reg_rstn_mode_n_en_y;

    localparam int unsigned DW    = 32;
    localparam logic [DW-1:0] RV0 = 32'h0000_0000;
    localparam logic [DW-1:0] RV1 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_rstn_mode_n_en_y_if #(.DATA_WIDTH(DW)) bus0 ();
    reg_rstn_mode_n_en_y_if #(.DATA_WIDTH(DW)) bus1 ();

    reg_rstn_mode_n_en_y #(.DATA_WIDTH(DW), .RST_VAL(RV0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0.slave)
    );

    reg_rstn_mode_n_en_y #(.DATA_WIDTH(DW), .RST_VAL(RV1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1.slave)
    );

    task automatic drive(input logic en, input logic [DW-1:0] data);
        bus0.i_en   = en;
        bus0.i_data = data;
        bus1.i_en   = en;
        bus1.i_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF);
        tick();
        total++;
        if (bus0.o_data !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL preload: got %h want %h", bus0.o_data, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus0.o_data !== RV0 || bus1.o_data !== RV1) begin
            bad++;
            $display("FAIL reset_immediate: got %h/%h want %h/%h",
                     bus0.o_data, bus1.o_data, RV0, RV1);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus0.o_data !== RV0 || bus1.o_data !== RV1) begin
                bad++;
                $display("FAIL reset_hold_edge%0d: got %h/%h want %h/%h",
                         i, bus0.o_data, bus1.o_data, RV0, RV1);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        drive(1'b0, 32'hFFFF_0000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drive(1'b0, 32'hFFFF_00FF);
            tick();
            total++;
            if (bus0.o_data !== RV0 || bus1.o_data !== RV1) begin
                bad++;
                $display("FAIL hold_edge%0d: got %h/%h want %h/%h",
                         i, bus0.o_data, bus1.o_data, RV0, RV1);
            end
        end
    endtask

    task automatic test_load();
        drive(1'b1, 32'hFFFF_FFFF);
        #3;
        total++;
        if (bus0.o_data !== RV0) begin
            bad++;
            $display("FAIL load_early: got %h want %h", bus0.o_data, RV0);
        end
        tick();
        total++;
        if (bus0.o_data !== 32'hFFFF_FFFF || bus1.o_data !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL load: got %h/%h want %h", bus0.o_data, bus1.o_data, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_enable_drop();
        drive(1'b0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus0.o_data !== 32'hFFFF_FFFF) begin
                bad++;
                $display("FAIL enable_drop_edge%0d: got %h want %h",
                         i, bus0.o_data, 32'hFFFF_FFFF);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus0.o_data !== RV0 || bus1.o_data !== RV1) begin
            bad++;
            $display("FAIL async_reset: got %h/%h want %h/%h",
                     bus0.o_data, bus1.o_data, RV0, RV1);
        end
        #2;
        rst_n = 1'b1;
        #1;
        total++;
        if (bus0.o_data !== RV0) begin
            bad++;
            $display("FAIL async_release: got %h want %h", bus0.o_data, RV0);
        end
        tick();
        total++;
        if (bus0.o_data !== RV0 || bus1.o_data !== RV1) begin
            bad++;
            $display("FAIL async_after_edge: got %h/%h want %h/%h",
                     bus0.o_data, bus1.o_data, RV0, RV1);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vec [3];
        vec[0] = 32'hA5A5_A5A5;
        vec[1] = 32'h5A5A_5A5A;
        vec[2] = 32'h0000_FFFF;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vec[i]);
            tick();
            total++;
            if (bus0.o_data !== vec[i] || bus1.o_data !== vec[i]) begin
                bad++;
                $display("FAIL b2b_%0d: got %h/%h want %h", i, bus0.o_data, bus1.o_data, vec[i]);
            end
        end
        // A data glitch between edges with the enable low must not reach the output.
        drive(1'b0, 32'h1111_1111);
        #3;
        drive(1'b0, 32'h2222_2222);
        tick();
        total++;
        if (bus0.o_data !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL b2b_hold: got %h want %h", bus0.o_data, 32'h0000_FFFF);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_load();
        test_enable_drop();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
